// File: rtl/gt_seq_pkg.sv
// Shared definitions for the sequential magnitude comparator: state encoding
// and default operand width.
package gt_seq_pkg;

   localparam int DEFAULT_WIDTH = 8;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_COMPARE = 2'd1;
   localparam logic [1:0] ST_DONE    = 2'd2;

   typedef enum logic [1:0] {
      IDLE    = ST_IDLE,
      COMPARE = ST_COMPARE,
      DONE    = ST_DONE
   } state_t;

endpackage

// File: rtl/greater_than_2bit.sv
// Combinational 2-bit unsigned greater-than; the single digit comparator that
// the sequencer time-multiplexes.
module greater_than_2bit (
   input  logic [1:0] a,
   input  logic [1:0] b,
   output logic       gt
);

   assign gt = (a[1] & ~b[1]) | (~(a[1] ^ b[1]) & a[0] & ~b[0]);

endmodule

// File: rtl/gt_compare_seq.sv
// Multi-cycle WIDTH-bit unsigned comparator, one 2-bit digit per cycle, MSB first.
// Optional macro GT_SEQ_EARLY_EXIT_EN: stop at the first differing digit.
module gt_compare_seq
   import gt_seq_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             eq,
   output logic             lt
);

   localparam int DIGITS = WIDTH / 2;
   localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] IDX_TOP = IW'(DIGITS - 1);

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [IW-1:0]    idx;
   logic [1:0]       a_dig [DIGITS];
   logic [1:0]       b_dig [DIGITS];
   logic [1:0]       a_cur;
   logic [1:0]       b_cur;
   logic             dig_gt;
   logic             dig_eq;
   logic             accept;
   logic             last;
`ifndef GT_SEQ_EARLY_EXIT_EN
   logic             decided;
   logic             dec_gt;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign a_dig[gi] = a_reg[2*gi+1:2*gi];
         assign b_dig[gi] = b_reg[2*gi+1:2*gi];
      end
   endgenerate

   // Explicit match mux keeps the select safe when DIGITS is not a power of two.
   always_comb begin
      a_cur = '0;
      b_cur = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IW'(i)) begin
            a_cur = a_dig[i];
            b_cur = b_dig[i];
         end
      end
   end

   greater_than_2bit u_cmp (
      .a  (a_cur),
      .b  (b_cur),
      .gt (dig_gt)
   );

   assign dig_eq = &(a_cur ~^ b_cur);
   assign accept = start && (state != COMPARE);
   assign last   = (idx == '0);
   assign busy   = (state == COMPARE);
   assign done   = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = COMPARE;
`ifdef GT_SEQ_EARLY_EXIT_EN
         COMPARE: if (!dig_eq || last) state_next = DONE;
`else
         COMPARE: if (last) state_next = DONE;
`endif
         DONE:    state_next = start ? COMPARE : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg   <= '0;
         b_reg   <= '0;
         idx     <= '0;
         gt      <= 1'b0;
         eq      <= 1'b0;
         lt      <= 1'b0;
`ifndef GT_SEQ_EARLY_EXIT_EN
         decided <= 1'b0;
         dec_gt  <= 1'b0;
`endif
      end else if (accept) begin
         a_reg   <= a;
         b_reg   <= b;
         idx     <= IDX_TOP;
         gt      <= 1'b0;
         eq      <= 1'b0;
         lt      <= 1'b0;
`ifndef GT_SEQ_EARLY_EXIT_EN
         decided <= 1'b0;
         dec_gt  <= 1'b0;
`endif
      end else if (state == COMPARE) begin
`ifdef GT_SEQ_EARLY_EXIT_EN
         if (!dig_eq) begin
            gt <= dig_gt;
            lt <= ~dig_gt;
            eq <= 1'b0;
         end else if (last) begin
            eq <= 1'b1;
         end else begin
            idx <= idx - 1'b1;
         end
`else
         // First differing digit wins; flags are only published on the last digit.
         if (!decided && !dig_eq) begin
            decided <= 1'b1;
            dec_gt  <= dig_gt;
         end
         if (last) begin
            if (decided) begin
               gt <= dec_gt;
               lt <= ~dec_gt;
            end else if (!dig_eq) begin
               gt <= dig_gt;
               lt <= ~dig_gt;
            end else begin
               eq <= 1'b1;
            end
         end else begin
            idx <= idx - 1'b1;
         end
`endif
      end
   end

endmodule
